// File: rtl/axi_write_feeder.sv
// Stream-to-write-engine feeder: buffers incoming words in a FIFO and issues one
// single-word write request per word to consecutive addresses of a job.
module axi_write_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic [31:0]              base_addr_in,
  input  logic [31:0]              word_count_in,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     write_en_out,
  output logic [31:0]              write_addr_out,
  output logic [31:0]              write_data_out,
  output logic [31:0]              write_data_len_out,
  input  logic                     write_done_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [$clog2(DEPTH):0]   level_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [2:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d, remaining_q, remaining_d;
  logic [31:0]   data_q, data_d, waddr_q, waddr_d;
  logic          wen_q, wen_d, done_q, done_d, busy_q, busy_d;
  logic          push_s, pop_s;

  // Ready is held low while reset is applied so nothing is pushed into a FIFO being cleared.
  assign in_ready = ~rst & (level_q < FULL_LEVEL);
  assign push_s   = in_valid & in_ready;
  assign pop_s    = (state_q == S_ISSUE);

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
  end

  // Job sequencing FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          addr_d      = base_addr_in;
          remaining_d = word_count_in;
          state_d     = (word_count_in == 32'd0) ? S_FINISH : S_WAIT_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (level_q != {(AW+1){1'b0}}) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT_DATA;
        end
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (write_done_in) begin
          remaining_d = remaining_q - 32'd1;
          addr_d      = addr_q + 32'd4;
          state_d     = (remaining_q == 32'd1) ? S_FINISH : S_WAIT_DATA;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output registers; address and data are captured on entry to ISSUE and held until the next request.
  always_comb begin
    wen_d   = (state_d == S_ISSUE);
    done_d  = (state_q == S_FINISH);
    busy_d  = (state_d != S_IDLE);
    data_d  = data_q;
    waddr_d = waddr_q;
    if (state_q == S_WAIT_DATA && state_d == S_ISSUE) begin
      data_d  = mem_q[rd_ptr_q];
      waddr_d = addr_q;
    end else begin
      data_d  = data_q;
      waddr_d = waddr_q;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {(AW+1){1'b0}};
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 32'd0;
      data_q      <= 32'd0;
      waddr_q     <= 32'd0;
      wen_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      waddr_q     <= waddr_d;
      wen_q       <= wen_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign write_en_out       = wen_q;
  assign write_addr_out     = waddr_q;
  assign write_data_out     = data_q;
  assign write_data_len_out = 32'd1;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign level_out          = level_q;

endmodule

// File: tb/tb_axi_write_feeder.sv
// Scoreboard bench for axi_write_feeder: expected addresses/data are queued as
// stimulus is applied and popped whenever a write request appears.
module tb_axi_write_feeder;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_in = 1'b0;
  logic [31:0]   base_addr_in = 32'd0;
  logic [31:0]   word_count_in = 32'd0;
  logic [31:0]   in_data = 32'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          write_en_out;
  logic [31:0]   write_addr_out;
  logic [31:0]   write_data_out;
  logic [31:0]   write_data_len_out;
  logic          write_done_in = 1'b0;
  logic          busy_out;
  logic          done_out;
  logic [LW-1:0] level_out;

  axi_write_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .base_addr_in(base_addr_in),
    .word_count_in(word_count_in), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .write_en_out(write_en_out), .write_addr_out(write_addr_out),
    .write_data_out(write_data_out), .write_data_len_out(write_data_len_out),
    .write_done_in(write_done_in), .busy_out(busy_out), .done_out(done_out),
    .level_out(level_out)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] data_sb_q[$];
  logic [31:0] addr_sb_q[$];
  int          wen_cnt = 0;
  int          done_cnt = 0;
  bit          auto_done = 1'b1;
  int          done_dly = 2;
  int          done_cd = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic cycle();
    logic        push_ok;
    logic [31:0] ea;
    logic [31:0] ed;
    @(negedge clk);
    push_ok = !rst && in_valid && (data_sb_q.size() < DEPTH);
    if (!rst && write_en_out) begin
      wen_cnt++;
      if (addr_sb_q.size() == 0 || data_sb_q.size() == 0) begin
        check_val("wen_unexpected", 32'd1, 32'd0);
      end else begin
        ea = addr_sb_q.pop_front();
        ed = data_sb_q.pop_front();
        check_val("write_addr", write_addr_out, ea);
        check_val("write_data", write_data_out, ed);
      end
      if (auto_done) done_cd = done_dly;
    end
    if (!rst && done_out) done_cnt++;
    if (push_ok) data_sb_q.push_back(in_data);
    @(posedge clk);
    #1;
    write_done_in = 1'b0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) write_done_in = 1'b1;
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] base, input int cnt);
    start_in      = 1'b1;
    base_addr_in  = base;
    word_count_in = 32'(cnt);
    for (int i = 0; i < cnt; i++) addr_sb_q.push_back(base + 32'(4 * i));
    cycle();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == d0; k++) cycle();
    check_val(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_wen(input string tag, input int budget);
    int w0 = wen_cnt;
    for (int k = 0; k < budget && wen_cnt == w0; k++) cycle();
    check_val(tag, 32'(wen_cnt - w0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wen"},   32'(write_en_out), 32'd0);
    check_val({tag, "_done"},  32'(done_out), 32'd0);
    check_val({tag, "_busy"},  32'(busy_out), 32'd0);
    check_val({tag, "_waddr"}, write_addr_out, 32'd0);
    check_val({tag, "_wdata"}, write_data_out, 32'd0);
    check_val({tag, "_level"}, 32'(level_out), 32'd0);
    check_val({tag, "_ready"}, 32'(in_ready), 32'd0);
    check_val({tag, "_len"},   write_data_len_out, 32'd1);
  endtask

  initial begin
    int w0;
    int d0;

    #12;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", 32'(in_ready), 32'd1);
    check_val("len_after_rst", write_data_len_out, 32'd1);

    // Preloaded three-word job.
    push_word(32'hA0);
    push_word(32'hA1);
    push_word(32'hA2);
    check_val("preload_level", 32'(level_out), 32'd3);
    w0 = wen_cnt;
    d0 = done_cnt;
    start_job(32'h1000, 3);
    wait_done("job3_done", 200);
    repeat (3) cycle();
    check_val("job3_wen_count", 32'(wen_cnt - w0), 32'd3);
    check_val("job3_done_pulses", 32'(done_cnt - d0), 32'd1);
    check_val("job3_level", 32'(level_out), 32'd0);

    // Zero-length job.
    w0 = wen_cnt;
    start_job(32'h5000, 0);
    check_val("cnt0_busy_c1", 32'(busy_out), 32'd1);
    check_val("cnt0_done_c1", 32'(done_out), 32'd0);
    cycle();
    check_val("cnt0_busy_c2", 32'(busy_out), 32'd0);
    check_val("cnt0_done_c2", 32'(done_out), 32'd1);
    cycle();
    check_val("cnt0_done_c3", 32'(done_out), 32'd0);
    check_val("cnt0_no_wen", 32'(wen_cnt - w0), 32'd0);

    // Fill to capacity, attempt an overflow push, then drain one word.
    for (int i = 0; i < DEPTH; i++) push_word(32'h100 + 32'(i));
    check_val("full_ready", 32'(in_ready), 32'd0);
    check_val("full_level", 32'(level_out), 32'd16);
    push_word(32'hBAD);
    check_val("overflow_level", 32'(level_out), 32'd16);
    start_job(32'h2000, 1);
    wait_done("one_done", 100);
    check_val("after_pop_ready", 32'(in_ready), 32'd1);
    check_val("after_pop_level", 32'(level_out), 32'd15);

    // Address wrap uses words retained from the previous job.
    start_job(32'hFFFF_FFFC, 2);
    wait_done("wrap_done", 100);
    check_val("wrap_last_addr", write_addr_out, 32'h0000_0000);
    check_val("wrap_level", 32'(level_out), 32'd13);

    // Reset in WAIT_DONE with five words buffered.
    rst = 1'b1;
    data_sb_q.delete();
    addr_sb_q.delete();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'hD0 + 32'(i));
    auto_done = 1'b0;
    start_job(32'h4000, 3);
    wait_wen("rst_job_wen", 50);
    check_val("rst_job_level", 32'(level_out), 32'd5);
    check_val("rst_job_busy", 32'(busy_out), 32'd1);
    rst = 1'b1;
    data_sb_q.delete();
    addr_sb_q.delete();
    #1;
    check_reset_outputs("rst_mid");
    cycle();
    rst = 1'b0;
    write_done_in = 1'b1;
    w0 = wen_cnt;
    repeat (6) cycle();
    check_val("late_done_busy", 32'(busy_out), 32'd0);
    check_val("late_done_level", 32'(level_out), 32'd0);
    check_val("late_done_no_wen", 32'(wen_cnt - w0), 32'd0);
    check_val("late_done_ready", 32'(in_ready), 32'd1);

    // Stalled completion with an ignored start, then push coinciding with done.
    push_word(32'hC0);
    w0 = wen_cnt;
    start_job(32'h3000, 2);
    wait_wen("stall_wen", 50);
    for (int i = 0; i < 20; i++) begin
      check_val("stall_addr", write_addr_out, 32'h3000);
      check_val("stall_data", write_data_out, 32'hC0);
      check_val("stall_busy", 32'(busy_out), 32'd1);
      if (i == 5) begin
        start_in      = 1'b1;
        base_addr_in  = 32'h9000;
        word_count_in = 32'd0;
      end else begin
        start_in = 1'b0;
      end
      cycle();
    end
    start_in      = 1'b0;
    in_valid      = 1'b1;
    in_data       = 32'hC1;
    write_done_in = 1'b1;
    auto_done     = 1'b1;
    done_dly      = 2;
    cycle();
    in_valid = 1'b0;
    check_val("post_done_addr_held", write_addr_out, 32'h3000);
    wait_done("stall_job_done", 100);
    check_val("stall_job_wens", 32'(wen_cnt - w0), 32'd2);
    check_val("stall_job_level", 32'(level_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_write_feeder.md
AXI_WRITE_FEEDER -- requirements
Module: axi_write_feeder

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-002 Parameter DEPTH, default 16, SHALL set the data FIFO depth in words, a power of two, at least 2.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start_in  in  1  job start; sampled only in IDLE
- base_addr_in  in  32  first byte address of the job
- word_count_in  in  32  number of 32-bit words in the job
- in_data  in  32  stream data word
- in_valid  in  1  stream data valid
- in_ready  out  1  FIFO can accept a word
- write_en_out  out  1  one-cycle request pulse to the write engine
- write_addr_out  out  32  target address of the current word
- write_data_out  out  32  current data word
- write_data_len_out  out  32  words per request; constant 1
- write_done_in  in  1  write engine completion pulse
- busy_out  out  1  job in progress (state other than IDLE)
- done_out  out  1  one-cycle pulse when the job completes
- level_out  out  clog2(DEPTH)+1  FIFO occupancy

Function
REQ-004 The FIFO SHALL accept a word on every rising clk edge where in_valid and in_ready are both high, in any state, so data can be preloaded before start_in.
REQ-005 in_ready SHALL equal "level_out < DEPTH".
REQ-006 FIFO pointers SHALL wrap modulo DEPTH.
REQ-007 A push and a pop in the same cycle SHALL leave level_out unchanged.
REQ-008 When full, a push SHALL NOT occur, because in_ready is low.
REQ-009 The FSM SHALL have exactly the states IDLE, WAIT_DATA, ISSUE, WAIT_DONE and FINISH.
REQ-010 In IDLE, start_in SHALL load addr <= base_addr_in and remaining <= word_count_in.
REQ-011 From IDLE on start_in, the FSM SHALL go to FINISH if word_count_in == 0, and to WAIT_DATA otherwise.
REQ-012 start_in SHALL be ignored in every state except IDLE.
REQ-013 In WAIT_DATA, the FSM SHALL move to ISSUE on the first cycle where the FIFO is non-empty.
REQ-014 In ISSUE:
- write_en_out SHALL be 1 for exactly that one cycle.
- The FIFO head SHALL be popped into a data register that drives write_data_out.
- The FSM SHALL go to WAIT_DONE.
REQ-015 write_addr_out and write_data_out SHALL be registered outputs. They SHALL be valid from the ISSUE cycle and held stable until the cycle after write_done_in, because the write engine reads write_data_out combinationally during its data phase.
REQ-016 write_data_len_out SHALL be held at 1 at all times.
REQ-017 In WAIT_DONE, on write_done_in:
- remaining SHALL be decremented by 1.
- addr SHALL be incremented by 4, wrapping modulo 2^32.
- The FSM SHALL go to FINISH if remaining was 1, and to WAIT_DATA otherwise.
REQ-018 write_done_in SHALL be ignored in every state except WAIT_DONE.
REQ-019 FINISH SHALL assert done_out for one cycle and return to IDLE.
REQ-020 Words left in the FIFO after a job SHALL be retained for the next job.
REQ-021 Request-to-request spacing SHALL be at least 3 cycles: ISSUE, WAIT_DONE (one or more cycles), then WAIT_DATA.
REQ-022 A write_done_in arriving in the same cycle as a push SHALL process both events.

Reset
REQ-023 While rst is high, the following SHALL be forced asynchronously:
- State IDLE.
- FIFO empty, level_out = 0.
- addr, remaining and the data register = 0.
- write_en_out, done_out, busy_out, write_addr_out and write_data_out = 0.
- in_ready = 0.
REQ-024 write_data_len_out SHALL read 1 during and after reset.
REQ-025 After rst deasserts, in_ready SHALL be 1.
REQ-026 Asserting rst mid-job SHALL abandon the job and discard all FIFO contents.
REQ-027 No write_en_out SHALL be issued after an rst assertion until a new start_in is received.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Preload 3 words (0xA0, 0xA1, 0xA2), then start base 0x1000, count 3, with done replies 2 cycles after each write_en -> exactly 3 write_en pulses, with (addr, data) = (0x1000, 0xA0), (0x1004, 0xA1), (0x1008, 0xA2), then one done_out pulse and level_out = 0.
- Start count 0 -> no write_en pulse, done_out exactly 2 cycles after start_in, busy_out high for 1 cycle.
- Push 16 words with DEPTH 16 and no start -> in_ready = 0 and level_out = 16; a 17th in_valid is not accepted; start count 1 -> after the pop, in_ready returns to 1.
- Start base 0xFFFFFFFC, count 2 -> second request address is 0x00000000.
- Assert rst while in WAIT_DONE with 5 words buffered -> all outputs 0 and level_out 0; a late write_done_in after reset produces no state change.
- Stall write_done_in for 20 cycles -> write_addr_out and write_data_out stay constant throughout; start_in pulsed during the job is ignored.
